// File: rtl/instr_fetch_seq_pkg.sv
// Shared CPU definitions: fetch sequencer state encoding and the default
// datapath widths used by the PC register, fetch unit and memory model.
package instr_fetch_seq_pkg;

    localparam int unsigned CPU_DATA_W     = 32;
    localparam int unsigned CPU_MEM_ADDR_W = 9;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] UPD  = 2'd2;

endpackage

// File: rtl/instr_fetch_seq_timeout_ctr.sv
// Bounded wait counter for memory handshakes. 'expired' is high during the
// last cycle the requester may still wait (count == TIMEOUT-1 while enabled),
// so the owner can leave its wait state on that same edge.
module fetch_timeout_ctr #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic clr,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    // Count enabled wait cycles; synchronous clear has priority.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && (count != LAST)) begin
            count <= count + CW'(1);
        end
    end

    assign expired = en && (count == LAST);

endmodule

// File: rtl/instr_fetch_seq.sv
// Instruction fetch sequencer: snapshots the PC, reads one word from
// instruction memory over a req/ack handshake, latches it into the
// instruction register and loads PC+1 into the PC register.
module instr_fetch_seq
    import instr_fetch_seq_pkg::*;
#(
    parameter int unsigned DATA_W     = CPU_DATA_W,
    parameter int unsigned MEM_ADDR_W = CPU_MEM_ADDR_W,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [DATA_W-1:0]     pc_q,
    input  logic                  fetch_req,
    input  logic                  flush,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic                  mem_rd,
    input  logic                  mem_ack,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic [DATA_W-1:0]     pc_d,
    output logic                  pc_en,
    output logic [DATA_W-1:0]     ir_q,
    output logic                  ir_valid,
    output logic                  busy,
    output logic                  fault
);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [DATA_W-1:0] pc_snap;
    logic              accept;
    logic              in_range;
    logic              ack_ok;
    logic              timed_out;
    logic              expired;

    // A flush blocks acceptance, acks and timeouts alike.
    assign accept    = (state == IDLE) && fetch_req && !flush;
    assign in_range  = (pc_q[DATA_W-1:MEM_ADDR_W] == '0);
    assign ack_ok    = (state == REQ) && !flush && mem_ack;
    assign timed_out = (state == REQ) && !flush && !mem_ack && expired;
    assign busy      = (state != IDLE);

    fetch_timeout_ctr #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .clr    (clr),
        .clear  (state != REQ),
        .en     ((state == REQ) && !mem_ack),
        .expired(expired)
    );

    // Next-state selection for the IDLE -> REQ -> UPD fetch sequence.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && in_range) state_nxt = REQ;
            REQ: begin
                if (flush || timed_out) state_nxt = IDLE;
                else if (mem_ack)       state_nxt = UPD;
            end
            UPD:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state <= IDLE;
        else      state <= state_nxt;
    end

    // Datapath: PC snapshot, memory request, instruction latch and PC load.
    // pc_d/pc_en are registered on the ack edge so the PC register loads at
    // the end of UPD and the next IDLE cycle already sees the new PC.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            pc_snap  <= '0;
            mem_addr <= '0;
            mem_rd   <= 1'b0;
            pc_d     <= '0;
            pc_en    <= 1'b0;
            ir_q     <= '0;
            ir_valid <= 1'b0;
            fault    <= 1'b0;
        end else begin
            fault  <= (accept && !in_range) || timed_out;
            pc_en  <= ack_ok;
            mem_rd <= (state_nxt == REQ);
            if (accept) begin
                pc_snap  <= pc_q;
                ir_valid <= 1'b0;
                if (in_range) mem_addr <= pc_q[MEM_ADDR_W-1:0];
            end
            if (ack_ok) begin
                ir_q <= mem_rdata;
                pc_d <= pc_snap + DATA_W'(1);
            end
            if (state == UPD) ir_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Self-checking bench for instr_fetch_seq: directed scenarios with literal
// expectations followed by randomized traffic against a transaction-level model.
module tb_instr_fetch_seq;

    localparam int DATA_W     = 32;
    localparam int MEM_ADDR_W = 9;
    localparam int TIMEOUT    = 15;

    logic                  clk = 1'b0;
    logic                  clr = 1'b1;
    logic [DATA_W-1:0]     pc_q;
    logic                  fetch_req = 1'b0;
    logic                  flush = 1'b0;
    logic [MEM_ADDR_W-1:0] mem_addr;
    logic                  mem_rd;
    logic                  mem_ack = 1'b0;
    logic [DATA_W-1:0]     mem_rdata = '0;
    logic [DATA_W-1:0]     pc_d;
    logic                  pc_en;
    logic [DATA_W-1:0]     ir_q;
    logic                  ir_valid;
    logic                  busy;
    logic                  fault;

    logic [DATA_W-1:0] pc_reg = '0;
    logic [DATA_W-1:0] pc_force = '0;
    logic              use_pcreg = 1'b0;
    logic              pc_zero = 1'b0;

    int tests = 0;
    int errors = 0;
    int n_rd = 0, n_pcen = 0, n_fault = 0;
    logic prev_rd = 1'b0;
    logic [MEM_ADDR_W-1:0] addr_q[$];

    instr_fetch_seq #(
        .DATA_W    (DATA_W),
        .MEM_ADDR_W(MEM_ADDR_W),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .pc_q     (pc_q),
        .fetch_req(fetch_req),
        .flush    (flush),
        .mem_addr (mem_addr),
        .mem_rd   (mem_rd),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata),
        .pc_d     (pc_d),
        .pc_en    (pc_en),
        .ir_q     (ir_q),
        .ir_valid (ir_valid),
        .busy     (busy),
        .fault    (fault)
    );

    always #5 clk = ~clk;

    assign pc_q = use_pcreg ? pc_reg : pc_force;

    // PC register fed by the sequencer.
    always @(posedge clk) begin
        if (pc_zero)    pc_reg <= '0;
        else if (pc_en) pc_reg <= pc_d;
    end

    // Transaction-level model: what each output must show after every edge.
    typedef struct packed {
        logic              req;
        logic              upd;
        int                waited;
        logic [DATA_W-1:0] snap;
        logic [MEM_ADDR_W-1:0] addr;
        logic              rd;
        logic [DATA_W-1:0] pcd;
        logic              pcen;
        logic [DATA_W-1:0] ir;
        logic              irv;
        logic              bsy;
        logic              flt;
    } mdl_t;

    mdl_t m = '0;

    function automatic mdl_t model_step(mdl_t c, logic fr, logic fl, logic ack,
                                        logic [DATA_W-1:0] rdata, logic [DATA_W-1:0] pc);
        mdl_t n = c;
        n.flt  = 1'b0;
        n.pcen = 1'b0;
        if (c.upd) begin
            n.upd = 1'b0;
            n.irv = 1'b1;
        end else if (c.req) begin
            if (fl) begin
                n.req = 1'b0;
            end else if (ack) begin
                n.req  = 1'b0;
                n.upd  = 1'b1;
                n.ir   = rdata;
                n.pcd  = c.snap + 32'd1;
                n.pcen = 1'b1;
            end else begin
                n.waited = c.waited + 1;
                if (n.waited == TIMEOUT) begin
                    n.req = 1'b0;
                    n.flt = 1'b1;
                end
            end
        end else if (fr && !fl) begin
            n.snap = pc;
            n.irv  = 1'b0;
            if ((pc >> MEM_ADDR_W) != 0) begin
                n.flt = 1'b1;
            end else begin
                n.req    = 1'b1;
                n.waited = 0;
                n.addr   = pc[MEM_ADDR_W-1:0];
            end
        end
        n.rd  = n.req;
        n.bsy = n.req || n.upd;
        return n;
    endfunction

    always @(posedge clk or negedge clr) begin
        if (!clr) m <= '0;
        else      m <= model_step(m, fetch_req, flush, mem_ack, mem_rdata, pc_q);
    end

    task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        chk("mem_addr", DATA_W'(mem_addr), DATA_W'(m.addr));
        chk("mem_rd", DATA_W'(mem_rd), DATA_W'(m.rd));
        chk("pc_d", pc_d, m.pcd);
        chk("pc_en", DATA_W'(pc_en), DATA_W'(m.pcen));
        chk("ir_q", ir_q, m.ir);
        chk("ir_valid", DATA_W'(ir_valid), DATA_W'(m.irv));
        chk("busy", DATA_W'(busy), DATA_W'(m.bsy));
        chk("fault", DATA_W'(fault), DATA_W'(m.flt));
    end

    // Event counters for the directed scenarios.
    always @(negedge clk) begin
        n_rd    <= n_rd + int'(mem_rd);
        n_pcen  <= n_pcen + int'(pc_en);
        n_fault <= n_fault + int'(fault);
        prev_rd <= mem_rd;
        if (mem_rd && !prev_rd) addr_q.push_back(mem_addr);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    int rd0, pcen0, flt0, q0;

    initial begin
        #1 clr = 1'b0;
        #20;
        chk("rst_mem_rd", DATA_W'(mem_rd), 0);
        chk("rst_busy", DATA_W'(busy), 0);
        chk("rst_ir_q", ir_q, 0);
        chk("rst_pc_d", pc_d, 0);
        chk("rst_fault", DATA_W'(fault), 0);
        step();
        clr = 1'b1;
        step();

        // Basic fetch, ack after two wait cycles.
        pcen0 = n_pcen;
        pc_force = 32'h10;
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        chk("basic_rd", DATA_W'(mem_rd), 1);
        chk("basic_addr0", DATA_W'(mem_addr), 32'h010);
        step();
        chk("basic_addr1", DATA_W'(mem_addr), 32'h010);
        step();
        chk("basic_addr2", DATA_W'(mem_addr), 32'h010);
        mem_ack = 1'b1;
        mem_rdata = 32'h12345678;
        step();
        mem_ack = 1'b0;
        chk("basic_pc_en", DATA_W'(pc_en), 1);
        chk("basic_pc_d", pc_d, 32'h11);
        chk("model_pcd", m.pcd, 32'h11);
        step();
        chk("basic_ir_q", ir_q, 32'h12345678);
        chk("basic_ir_valid", DATA_W'(ir_valid), 1);
        step();
        chk("basic_pcen_cnt", n_pcen - pcen0, 1);

        // Range error.
        rd0 = n_rd; pcen0 = n_pcen;
        pc_force = 32'h200;
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        chk("range_fault", DATA_W'(fault), 1);
        chk("model_range_fault", DATA_W'(m.flt), 1);
        step();
        chk("range_fault_pulse", DATA_W'(fault), 0);
        step();
        chk("range_no_rd", n_rd - rd0, 0);
        chk("range_no_pcen", n_pcen - pcen0, 0);

        // Timeout.
        rd0 = n_rd; flt0 = n_fault;
        pc_force = 32'h5;
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        repeat (20) step();
        chk("tmo_rd_cycles", n_rd - rd0, 15);
        chk("tmo_fault_cnt", n_fault - flt0, 1);
        chk("tmo_ir_q", ir_q, 32'h12345678);
        chk("tmo_busy", DATA_W'(busy), 0);

        // Flush and ack in the same cycle.
        pcen0 = n_pcen;
        pc_force = 32'h7;
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        flush = 1'b1;
        mem_ack = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        step();
        flush = 1'b0;
        mem_ack = 1'b0;
        chk("flush_busy", DATA_W'(busy), 0);
        chk("flush_ir_q", ir_q, 32'h12345678);
        step();
        chk("flush_no_pcen", n_pcen - pcen0, 0);

        // Reset in the middle of a request.
        pc_force = 32'h20;
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        chk("midrst_rd_before", DATA_W'(mem_rd), 1);
        pcen0 = n_pcen;
        clr = 1'b0;
        #1;
        chk("midrst_rd", DATA_W'(mem_rd), 0);
        chk("midrst_busy", DATA_W'(busy), 0);
        chk("midrst_ir_valid", DATA_W'(ir_valid), 0);
        chk("midrst_pc_en", DATA_W'(pc_en), 0);
        step();
        clr = 1'b1;
        repeat (3) step();
        chk("midrst_no_pcen", n_pcen - pcen0, 0);

        // Back-to-back fetches through the PC register.
        pc_zero = 1'b1;
        step();
        pc_zero = 1'b0;
        use_pcreg = 1'b1;
        mem_ack = 1'b1;
        q0 = addr_q.size();
        pcen0 = n_pcen;
        fetch_req = 1'b1;
        repeat (10) step();
        fetch_req = 1'b0;
        repeat (4) step();
        mem_ack = 1'b0;
        chk("b2b_enough", DATA_W'(addr_q.size() - q0 >= 3), 1);
        if (addr_q.size() - q0 >= 3) begin
            chk("b2b_addr0", DATA_W'(addr_q[q0]), 0);
            chk("b2b_addr1", DATA_W'(addr_q[q0+1]), 1);
            chk("b2b_addr2", DATA_W'(addr_q[q0+2]), 2);
        end
        chk("b2b_pcen_per_fetch", n_pcen - pcen0, addr_q.size() - q0);
        chk("b2b_pc_final", pc_reg, 4);
        use_pcreg = 1'b0;

        // Randomized traffic checked by the per-cycle compare.
        for (int i = 0; i < 3000; i++) begin
            fetch_req = ($urandom % 2) == 0;
            flush     = ($urandom % 10) == 0;
            mem_ack   = ($urandom % 4) == 0;
            mem_rdata = $urandom;
            pc_force  = (($urandom % 8) == 0) ? $urandom : $urandom_range(0, 511);
            if (($urandom % 500) == 0) begin
                clr = 1'b0;
                step();
                clr = 1'b1;
            end
            step();
        end
        fetch_req = 1'b0;
        flush = 1'b0;
        mem_ack = 1'b0;
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
